// File: rtl/ds_synth_pkg.sv
// ds_synth_pkg: shared types and widths for the synthesizer burst path
// Contents: FSM state encoding, field widths, signal-type codes, period helper.
package ds_synth_pkg;
  localparam int PER_W  = 13;
  localparam int IMP_W  = 10;
  localparam int NUM_W  = 6;
  localparam int ADDR_W = 5;
  typedef enum logic [2:0] {IDLE, LOAD, PULSE, GAP, FINISH} pts_state_t;
  typedef enum logic [1:0] {SIG_CARRIER, SIG_LFM, SIG_PSK, SIG_NONE} sig_type_t;
  // A zero period would never terminate a pulse, so it runs as 1 us.
  function automatic logic [PER_W-1:0] eff_period(input logic [PER_W-1:0] p);
    return (p == '0) ? PER_W'(1) : p;
  endfunction
endpackage

// File: rtl/pts_period_table.sv
// pts_period_table: period table, one write port, one registered read-first read port
// Ports:
//   clk          clock
//   we/waddr/wdata  write port
//   re/raddr     read request; rdata updates on the next edge only when re=1
//   rdata        registered read data (old contents on a same-address write)
module pts_period_table import ds_synth_pkg::*; #(
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PER_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PER_W-1:0]  rdata
);
  logic [PER_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pulse_train_sequencer.sv
// pulse_train_sequencer: turns a start edge plus burst config into a pulse gate, strobe and index
// Ports:
//   CLK, RESET (async, active-low)
//   ABORT            present only when PTS_ABORT_EN is defined; kills a burst, no DONE
//   SIGN_START_GEN   burst request, rising edge starts a burst
//   T_IMPULSE, NUM_OF_IMP, VOBULATION  burst config, latched in LOAD
//   TBL_WE, TBL_ADDR, TBL_DATA         period table write port (us)
//   IMP_GATE, IMP_START, IMP_IDX, BUSY, DONE  registered outputs
module pulse_train_sequencer import ds_synth_pkg::*; #(
  parameter int CLK_PER_US = 500,
  parameter int TBL_DEPTH  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
`ifdef PTS_ABORT_EN
  input  logic              ABORT,
`endif
  input  logic              SIGN_START_GEN,
  input  logic [IMP_W-1:0]  T_IMPULSE,
  input  logic [NUM_W-1:0]  NUM_OF_IMP,
  input  logic              VOBULATION,
  input  logic              TBL_WE,
  input  logic [ADDR_W-1:0] TBL_ADDR,
  input  logic [PER_W-1:0]  TBL_DATA,
  output logic              IMP_GATE,
  output logic              IMP_START,
  output logic [NUM_W-1:0]  IMP_IDX,
  output logic              BUSY,
  output logic              DONE
);
  localparam int PRE_W = $clog2(CLK_PER_US);
  pts_state_t state;
  logic sig_cur, sig_prev, start, abort;
  logic [PRE_W-1:0] pre;
  logic [PER_W-1:0] us, per_q;
  logic [PER_W:0] us_inc;
  logic [IMP_W-1:0] t_imp;
  logic [NUM_W-1:0] n_imp, idx_inc;
  logic vob, us_tick, per_end, imp_end, last, in_burst, rd_en;
  logic [ADDR_W-1:0] rd_addr;
`ifdef PTS_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif
  assign start    = sig_cur & ~sig_prev;
  assign us_tick  = pre == PRE_W'(CLK_PER_US - 1);
  assign us_inc   = {1'b0, us} + 1'b1;
  assign per_end  = us_tick && us_inc == {1'b0, eff_period(per_q)};
  assign imp_end  = us_tick && us_inc == (PER_W+1)'(t_imp);
  assign idx_inc  = IMP_IDX + 1'b1;
  assign last     = idx_inc == n_imp;
  assign in_burst = state == PULSE || state == GAP;
  // The next period is read on the last cycle of the current pulse, so rdata
  // switches exactly as the next pulse begins and no cycle is lost.
  assign rd_en   = state == LOAD || (in_burst && per_end);
  assign rd_addr = (state == LOAD || !vob) ? '0 : ADDR_W'(idx_inc % TBL_DEPTH);
  pts_period_table #(.DEPTH(TBL_DEPTH)) u_tbl (
    .clk(CLK), .we(TBL_WE), .waddr(TBL_ADDR), .wdata(TBL_DATA),
    .re(rd_en), .raddr(rd_addr), .rdata(per_q)
  );
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      sig_cur <= 1'b0;
      sig_prev <= 1'b0;
      pre <= '0;
      us <= '0;
      t_imp <= '0;
      n_imp <= '0;
      vob <= 1'b0;
      IMP_GATE <= 1'b0;
      IMP_START <= 1'b0;
      IMP_IDX <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      sig_cur <= SIGN_START_GEN;
      sig_prev <= sig_cur;
      IMP_START <= 1'b0;
      DONE <= 1'b0;
      pre <= us_tick ? '0 : pre + 1'b1;
      if (us_tick) us <= us_inc[PER_W-1:0];
      if (abort && state != IDLE) begin
        state <= IDLE;
        IMP_GATE <= 1'b0;
        BUSY <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= LOAD;
            BUSY <= 1'b1;
            t_imp <= T_IMPULSE;
            n_imp <= NUM_OF_IMP;
            vob <= VOBULATION;
            IMP_IDX <= '0;
          end
          LOAD: if (n_imp == '0) begin
            state <= FINISH;
            BUSY <= 1'b0;
            DONE <= 1'b1;
          end else begin
            state <= (t_imp == '0) ? GAP : PULSE;
            IMP_START <= 1'b1;
            IMP_GATE <= t_imp != '0;
            pre <= '0;
            us <= '0;
          end
          PULSE, GAP: if (per_end) begin
            if (last) begin
              state <= FINISH;
              IMP_GATE <= 1'b0;
              BUSY <= 1'b0;
              DONE <= 1'b1;
            end else begin
              state <= (t_imp == '0) ? GAP : PULSE;
              IMP_START <= 1'b1;
              IMP_GATE <= t_imp != '0;
              IMP_IDX <= idx_inc;
              pre <= '0;
              us <= '0;
            end
          end else if (state == PULSE && imp_end) begin
            state <= GAP;
            IMP_GATE <= 1'b0;
          end
          FINISH: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pulse_train_sequencer.sv
// tb_pulse_train_sequencer: self-checking bench with a burst-level timing model
module tb_pulse_train_sequencer;
  localparam int CPU = 4;
  localparam int MAXC = 4096;
  logic CLK = 1'b0, RESET = 1'b0;
`ifdef PTS_ABORT_EN
  logic ABORT = 1'b0;
`endif
  logic SIGN_START_GEN = 1'b0, VOBULATION = 1'b0, TBL_WE = 1'b0;
  logic [9:0] T_IMPULSE = '0;
  logic [5:0] NUM_OF_IMP = '0;
  logic [4:0] TBL_ADDR = '0;
  logic [12:0] TBL_DATA = '0;
  logic IMP_GATE, IMP_START, BUSY, DONE;
  logic [5:0] IMP_IDX;
  int errs = 0, checks = 0;
  int tbl [32];
  bit eg [MAXC], es [MAXC], eb [MAXC], ed [MAXC];
  int ei [MAXC];
  int len, rc, obs_done, busy_cnt, gate_cnt;
  int starts [$];
  bit chk_en = 1'b0;

  pulse_train_sequencer #(.CLK_PER_US(CPU)) dut (
    .CLK(CLK), .RESET(RESET),
`ifdef PTS_ABORT_EN
    .ABORT(ABORT),
`endif
    .SIGN_START_GEN(SIGN_START_GEN), .T_IMPULSE(T_IMPULSE), .NUM_OF_IMP(NUM_OF_IMP),
    .VOBULATION(VOBULATION), .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
    .IMP_GATE(IMP_GATE), .IMP_START(IMP_START), .IMP_IDX(IMP_IDX), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Burst model: lay pulses end to end, each Tp*CPU clocks long, gate for
  // min(T,Tp)*CPU clocks. Index j is negedges after the request is raised;
  // the first strobe lands at j=3, BUSY starts at j=2.
  task automatic build(input int t_imp, input int n, input int vob);
    int t, p, g;
    for (int j = 0; j < MAXC; j++) begin
      eg[j] = 0; es[j] = 0; eb[j] = 0; ed[j] = 0; ei[j] = -1;
    end
    t = 0;
    for (int k = 0; k < n; k++) begin
      p = tbl[vob != 0 ? k % 32 : 0];
      if (p == 0) p = 1;
      g = (t_imp < p ? t_imp : p) * CPU;
      p = p * CPU;
      for (int i = 0; i < p; i++) begin
        es[t+i+3] = (i == 0);
        eg[t+i+3] = (i < g);
        ei[t+i+3] = k;
      end
      t += p;
    end
    for (int j = 2; j < t + 3; j++) eb[j] = 1;
    ed[t+3] = 1;
    len = t + 8;
  endtask

  always @(negedge CLK) if (chk_en) begin
    chk("gate", int'(IMP_GATE), int'(eg[rc]));
    chk("start", int'(IMP_START), int'(es[rc]));
    chk("busy", int'(BUSY), int'(eb[rc]));
    chk("done", int'(DONE), int'(ed[rc]));
    if (ei[rc] >= 0) chk("idx", int'(IMP_IDX), ei[rc]);
    if (IMP_START) starts.push_back(rc - 3);
    if (DONE && obs_done < 0) obs_done = rc - 3;
    busy_cnt += int'(BUSY);
    gate_cnt += int'(IMP_GATE);
    rc++;
  end

  task automatic run(input int t_imp, input int n, input int vob, input int cut);
    int stop;
    build(t_imp, n, vob);
    stop = (cut > 0) ? cut : len;
    @(posedge CLK); #1;
    T_IMPULSE = 10'(t_imp); NUM_OF_IMP = 6'(n); VOBULATION = vob[0];
    starts.delete(); obs_done = -1; busy_cnt = 0; gate_cnt = 0; rc = 0;
    chk_en = 1'b1; SIGN_START_GEN = 1'b1;
    for (int j = 0; j < stop; j++) begin
      @(negedge CLK);
      // Config changes after LOAD must have no effect; later re-edges land mid-burst.
      if (j == 4) begin
        SIGN_START_GEN = 1'b0; T_IMPULSE = 10'd7; NUM_OF_IMP = 6'd1; VOBULATION = ~VOBULATION;
      end
      if (j == 200) SIGN_START_GEN = 1'b1;
      if (j == 210) SIGN_START_GEN = 1'b0;
    end
    #1 chk_en = 1'b0;
  endtask

  task automatic tbl_write(input int a, input int d);
    @(posedge CLK); #1;
    TBL_WE = 1'b1; TBL_ADDR = 5'(a); TBL_DATA = 13'(d); tbl[a] = d;
    @(posedge CLK); #1;
    TBL_WE = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_gate", int'(IMP_GATE), 0);
    chk("rst_start", int'(IMP_START), 0);
    chk("rst_idx", int'(IMP_IDX), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    @(negedge CLK); RESET = 1'b1;
    for (int i = 0; i < 32; i++) tbl_write(i, i + 2);
    repeat (3) @(posedge CLK);

    run(1, 3, 1, 0);
    chk("vob_done_at", obs_done, 36);
    chk("vob_nstarts", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("vob_start1", starts[1], 8);
      chk("vob_start2", starts[2], 20);
    end
    chk("vob_gate_cycles", gate_cnt, 12);

    run(1, 3, 0, 0);
    chk("fix_done_at", obs_done, 24);
    if (starts.size() == 3) chk("fix_start2", starts[2], 16);

    run(1, 0, 1, 0);
    chk("n0_done_at", obs_done, 0);
    chk("n0_nstarts", starts.size(), 0);
    chk("n0_busy_cycles", busy_cnt, 1);

    run(5, 2, 0, 0);
    chk("long_gate_cycles", gate_cnt, 16);
    chk("long_nstarts", starts.size(), 2);

    tbl_write(0, 0);
    run(0, 2, 0, 0);
    chk("tp0_done_at", obs_done, 8);
    chk("tp0_gate_cycles", gate_cnt, 0);
    tbl_write(0, 2);

    run(1, 40, 1, 0);
    chk("n40_nstarts", starts.size(), 40);
    if (starts.size() == 40) chk("n40_wrap_period", starts[33] - starts[32], 8);
    chk("n40_done_at", obs_done, 2416);

    run(1, 3, 1, 13);
    RESET = 1'b0; #1;
    chk("arst_gate", int'(IMP_GATE), 0);
    chk("arst_idx", int'(IMP_IDX), 0);
    chk("arst_busy", int'(BUSY), 0);
    @(negedge CLK); #1 RESET = 1'b1;
    repeat (3) @(posedge CLK);
    run(1, 3, 1, 0);
    chk("restart_done_at", obs_done, 36);

`ifdef PTS_ABORT_EN
    run(1, 3, 1, 13);
    ABORT = 1'b1;
    @(posedge CLK); #1 ABORT = 1'b0;
    chk("abort_gate", int'(IMP_GATE), 0);
    chk("abort_busy", int'(BUSY), 0);
    gate_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge CLK);
      gate_cnt += int'(DONE) + int'(BUSY) + int'(IMP_START);
    end
    chk("abort_quiet", gate_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
